// File: rtl/ase_pkg.sv
// Shared CCI-P header types and tag-field constants for the C0 Tx read arbiter.
// The arbiter tag occupies mdata[15:14] on both the request and the response path.
package ase_pkg;

    localparam int CCIP_DATA_WIDTH  = 512;
    localparam int CCIP_ARB_TAG_MSB = 15;
    localparam int CCIP_ARB_TAG_LSB = 14;

    typedef struct packed {
        logic [1:0]  vc_sel;
        logic [1:0]  rsvd1;
        logic [1:0]  cl_len;
        logic [3:0]  req_type;
        logic [5:0]  rsvd0;
        logic [41:0] address;
        logic [15:0] mdata;
    } TxHdr_t;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic [1:0]  rsvd0;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } RxHdr_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2
    } arb_state_e;

    function automatic logic [15:0] set_tag(input logic [15:0] mdata, input logic [1:0] tag);
        logic [15:0] m;
        m = mdata;
        m[CCIP_ARB_TAG_MSB:CCIP_ARB_TAG_LSB] = tag;
        return m;
    endfunction

endpackage

// File: rtl/ccip_rr_picker.sv
// Combinational round-robin picker: the first eligible requester at or after
// the pointer (wrapping) wins; output is one-hot plus its binary index.
module ccip_rr_picker #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] pointer,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        idx       = 0;
        // Walk from the farthest offset back to the pointer so the nearest eligible one wins.
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(pointer) + k) % N;
            if (eligible[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/ccip_c0tx_arbiter.sv
// Round-robin arbiter for CCI-P C0 read requests: tags each read with the
// requester index, tracks per-requester outstanding reads and routes responses back.
module ccip_c0tx_arbiter
    import ase_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 32
) (
    input  logic                       clk,
    input  logic                       SoftReset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  TxHdr_t                     req_hdr [NUM_REQ],
    output logic [NUM_REQ-1:0]         req_grant,
    output TxHdr_t                     C0TxHdr,
    output logic                       C0TxRdValid,
    input  logic                       C0TxAlmFull,
    input  RxHdr_t                     C0RxHdr,
    input  logic [CCIP_DATA_WIDTH-1:0] C0RxData,
    input  logic                       C0RxRdValid,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output RxHdr_t                     rsp_hdr,
    output logic [CCIP_DATA_WIDTH-1:0] rsp_data,
    input  logic                       drain_req,
    output logic                       drain_done,
    output logic                       tag_err
);

    localparam int PW = $clog2(NUM_REQ);

    logic [7:0]                 cnt_q [NUM_REQ];
    logic [7:0]                 cnt_d [NUM_REQ];
    logic [PW-1:0]              ptr_q, ptr_d;
    arb_state_e                 state_q, state_d;
    logic                       tx_valid_q, tx_valid_d;
    TxHdr_t                     tx_hdr_q, tx_hdr_d;
    logic [NUM_REQ-1:0]         rsp_valid_q, rsp_valid_d;
    RxHdr_t                     rsp_hdr_q, rsp_hdr_d;
    logic [CCIP_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                       tag_err_q, tag_err_d;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      grant_idx;
    logic [1:0]         rx_tag;
    logic [NUM_REQ-1:0] rx_hit;
    logic               rx_bad;
    logic               all_zero_d;

    // Reset gates eligibility so no grant can leak out while SoftReset is high.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (cnt_q[i] < 8'(MAX_OUTSTANDING)) &&
                          !C0TxAlmFull && (state_q == ST_RUN) && !SoftReset;
        end
    end

    ccip_rr_picker #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_picker (
        .eligible  (eligible),
        .pointer   (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign rx_tag = C0RxHdr.mdata[CCIP_ARB_TAG_MSB:CCIP_ARB_TAG_LSB];

    // A response only routes if its tag names a requester with a read outstanding.
    always_comb begin
        rx_hit = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rx_hit[i] = C0RxRdValid && (rx_tag == 2'(i)) && (cnt_q[i] != 8'd0);
        end
    end

    assign rx_bad = C0RxRdValid && (rx_hit == '0);

    always_comb begin
        all_zero_d = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grant[i] && !rx_hit[i]) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end else if (!grant[i] && rx_hit[i]) begin
                cnt_d[i] = cnt_q[i] - 8'd1;
            end
            if (cnt_d[i] != 8'd0) begin
                all_zero_d = 1'b0;
            end
        end
    end

    always_comb begin
        tx_valid_d = |grant;
        tx_hdr_d   = tx_hdr_q;
        ptr_d      = ptr_q;
        if (|grant) begin
            tx_hdr_d       = req_hdr[grant_idx];
            tx_hdr_d.mdata = set_tag(req_hdr[grant_idx].mdata, 2'(grant_idx));
            ptr_d          = grant_idx + 1'b1;
        end
    end

    always_comb begin
        rsp_valid_d = rx_hit;
        rsp_hdr_d   = rsp_hdr_q;
        rsp_data_d  = rsp_data_q;
        tag_err_d   = tag_err_q | rx_bad;
        if (|rx_hit) begin
            rsp_hdr_d       = C0RxHdr;
            rsp_hdr_d.mdata = set_tag(C0RxHdr.mdata, 2'b00);
            rsp_data_d      = C0RxData;
        end
    end

    // Drained means nothing outstanding after this cycle and no read still on the Tx bus.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (drain_req) state_d = ST_DRAIN;
            ST_DRAIN:   if (all_zero_d && !tx_valid_q) state_d = ST_DRAINED;
            ST_DRAINED: if (!drain_req) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (SoftReset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= 8'd0;
            end
            ptr_q       <= '0;
            state_q     <= ST_RUN;
            tx_valid_q  <= 1'b0;
            tx_hdr_q    <= '0;
            rsp_valid_q <= '0;
            rsp_hdr_q   <= '0;
            rsp_data_q  <= '0;
            tag_err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ptr_q       <= ptr_d;
            state_q     <= state_d;
            tx_valid_q  <= tx_valid_d;
            tx_hdr_q    <= tx_hdr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hdr_q   <= rsp_hdr_d;
            rsp_data_q  <= rsp_data_d;
            tag_err_q   <= tag_err_d;
        end
    end

    assign req_grant   = grant;
    assign C0TxRdValid = tx_valid_q;
    assign C0TxHdr     = tx_hdr_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_hdr     = rsp_hdr_q;
    assign rsp_data    = rsp_data_q;
    assign drain_done  = (state_q == ST_DRAINED);
    assign tag_err     = tag_err_q;

endmodule

// File: tb/tb_ccip_c0tx_arbiter.sv
// Bench for ccip_c0tx_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of grants, outstanding counts and drain state.
module tb_ccip_c0tx_arbiter;
    import ase_pkg::*;

    localparam int NREQ = 4;
    localparam int MAXO = 2;

    logic                       clk;
    logic                       SoftReset;
    logic [NREQ-1:0]            req_valid;
    TxHdr_t                     req_hdr [NREQ];
    logic [NREQ-1:0]            req_grant;
    TxHdr_t                     C0TxHdr;
    logic                       C0TxRdValid;
    logic                       C0TxAlmFull;
    RxHdr_t                     C0RxHdr;
    logic [CCIP_DATA_WIDTH-1:0] C0RxData;
    logic                       C0RxRdValid;
    logic [NREQ-1:0]            rsp_valid;
    RxHdr_t                     rsp_hdr;
    logic [CCIP_DATA_WIDTH-1:0] rsp_data;
    logic                       drain_req;
    logic                       drain_done;
    logic                       tag_err;

    int checks = 0;
    int errors = 0;

    // Model state
    int                         m_cnt [NREQ];
    int                         m_last;
    int                         m_mode;   // 0 running, 1 draining, 2 drained
    bit                         m_err;
    bit                         e_txv;
    TxHdr_t                     e_txhdr;
    logic [NREQ-1:0]            e_rspv;
    RxHdr_t                     e_rsphdr;
    logic [CCIP_DATA_WIDTH-1:0] e_rspd;

    ccip_c0tx_arbiter #(
        .NUM_REQ         (NREQ),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk         (clk),
        .SoftReset   (SoftReset),
        .req_valid   (req_valid),
        .req_hdr     (req_hdr),
        .req_grant   (req_grant),
        .C0TxHdr     (C0TxHdr),
        .C0TxRdValid (C0TxRdValid),
        .C0TxAlmFull (C0TxAlmFull),
        .C0RxHdr     (C0RxHdr),
        .C0RxData    (C0RxData),
        .C0RxRdValid (C0RxRdValid),
        .rsp_valid   (rsp_valid),
        .rsp_hdr     (rsp_hdr),
        .rsp_data    (rsp_data),
        .drain_req   (drain_req),
        .drain_done  (drain_done),
        .tag_err     (tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        m_last   = NREQ - 1;
        m_mode   = 0;
        m_err    = 1'b0;
        e_txv    = 1'b0;
        e_txhdr  = '0;
        e_rspv   = '0;
        e_rsphdr = '0;
        e_rspd   = '0;
    endtask

    // Requester the spec's rules would grant this cycle, or -1.
    function automatic int model_pick();
        if (SoftReset || C0TxAlmFull || m_mode != 0) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_last + k) % NREQ;
            if (req_valid[i] && m_cnt[i] < MAXO) return i;
        end
        return -1;
    endfunction

    // Apply current inputs to the model, then move one clock forward.
    task automatic advance();
        int g;
        int t;
        bit old_txv;
        bit all0;
        g = model_pick();
        old_txv = e_txv;
        if (SoftReset) begin
            model_reset();
        end else begin
            e_rspv = '0;
            if (C0RxRdValid) begin
                t = int'(C0RxHdr.mdata[15:14]);
                if (t >= NREQ || m_cnt[t] == 0) begin
                    m_err = 1'b1;
                end else begin
                    m_cnt[t]--;
                    e_rspv[t] = 1'b1;
                    e_rsphdr = C0RxHdr;
                    e_rsphdr.mdata[15:14] = 2'b00;
                    e_rspd = C0RxData;
                end
            end
            e_txv = (g >= 0);
            if (g >= 0) begin
                e_txhdr = req_hdr[g];
                e_txhdr.mdata[15:14] = 2'(g);
                m_cnt[g]++;
                m_last = g;
            end
            all0 = 1'b1;
            for (int i = 0; i < NREQ; i++) if (m_cnt[i] != 0) all0 = 1'b0;
            case (m_mode)
                0: if (drain_req) m_mode = 1;
                1: if (all0 && !old_txv) m_mode = 2;
                default: if (!drain_req) m_mode = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_hdrs();
        for (int i = 0; i < NREQ; i++) begin
            req_hdr[i] = '0;
            req_hdr[i].address  = {10'($urandom), $urandom};
            req_hdr[i].req_type = 4'($urandom);
            req_hdr[i].cl_len   = 2'($urandom);
            req_hdr[i].mdata    = {2'b00, 14'($urandom)};
        end
    endtask

    task automatic set_rsp(input int tag, input logic [13:0] low);
        C0RxRdValid = 1'b1;
        C0RxHdr = '0;
        C0RxHdr.resp_type = 4'($urandom);
        C0RxHdr.cl_num    = 2'($urandom);
        C0RxHdr.mdata     = {2'(tag), low};
        for (int w = 0; w < CCIP_DATA_WIDTH / 32; w++) C0RxData[w*32 +: 32] = $urandom;
    endtask

    task automatic idle_inputs();
        req_valid   = '0;
        C0TxAlmFull = 1'b0;
        C0RxRdValid = 1'b0;
        C0RxHdr     = '0;
        C0RxData    = '0;
        drain_req   = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        SoftReset = 1'b1;
        advance();
        SoftReset = 1'b0;
    endtask

    task automatic test_reset();
        SoftReset = 1'b1;
        req_valid = '1;
        rand_hdrs();
        set_rsp(1, 14'h3);
        drain_req = 1'b1;
        #3;
        checks++;
        if (req_grant !== 4'b0000) begin
            errors++; $display("FAIL reset_grant: got %b expected 0000", req_grant);
        end
        advance();
        advance();
        idle_inputs();
        #3;
        checks++;
        if (C0TxRdValid !== 1'b0 || C0TxHdr !== '0) begin
            errors++; $display("FAIL reset_tx: valid %b hdr %h expected 0 / 0", C0TxRdValid, C0TxHdr);
        end
        checks++;
        if (rsp_valid !== '0 || rsp_hdr !== '0 || rsp_data !== '0) begin
            errors++; $display("FAIL reset_rsp: valid %b hdr %h expected all zero", rsp_valid, rsp_hdr);
        end
        checks++;
        if (drain_done !== 1'b0 || tag_err !== 1'b0) begin
            errors++; $display("FAIL reset_flags: drain_done %b tag_err %b expected 0 0", drain_done, tag_err);
        end
        SoftReset = 1'b0;
        advance();
    endtask

    task automatic test_round_robin();
        int     exp_seq [5] = '{0, 1, 2, 3, 0};
        TxHdr_t sent [5];
        TxHdr_t exp_h;
        apply_reset();
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) req_valid = '0;
            rand_hdrs();
            #3;
            if (k < 5) begin
                checks++;
                if (req_grant !== 4'(1 << exp_seq[k])) begin
                    errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_grant, 4'(1 << exp_seq[k]));
                end
                sent[k] = req_hdr[exp_seq[k]];
            end
            if (k > 0) begin
                exp_h = sent[k-1];
                exp_h.mdata[15:14] = 2'(exp_seq[k-1]);
                checks++;
                if (C0TxRdValid !== 1'b1 || C0TxHdr !== exp_h) begin
                    errors++; $display("FAIL rr_tx[%0d]: valid %b hdr %h expected 1 / %h", k, C0TxRdValid, C0TxHdr, exp_h);
                end
            end
            advance();
        end
        #3;
        checks++;
        if (C0TxRdValid !== 1'b0 || C0TxHdr !== exp_h) begin
            errors++; $display("FAIL rr_tx_hold: valid %b hdr %h expected 0 / %h", C0TxRdValid, C0TxHdr, exp_h);
        end
        advance();
    endtask

    task automatic test_almfull();
        apply_reset();
        req_valid = 4'hF;
        advance();
        advance();
        C0TxAlmFull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #3;
            checks++;
            if (req_grant !== 4'b0000) begin
                errors++; $display("FAIL almfull_grant[%0d]: got %b expected 0000", k, req_grant);
            end
            advance();
        end
        C0TxAlmFull = 1'b0;
        #3;
        checks++;
        if (req_grant !== 4'b0100) begin
            errors++; $display("FAIL almfull_resume: got %b expected 0100", req_grant);
        end
        advance();
    endtask

    task automatic test_max_outstanding();
        int ng;
        apply_reset();
        req_valid = 4'b0010;
        ng = 0;
        for (int k = 0; k < 6; k++) begin
            #3;
            if (req_grant[1] === 1'b1) ng++;
            advance();
        end
        checks++;
        if (ng != MAXO) begin
            errors++; $display("FAIL max_out_grants: got %0d expected %0d", ng, MAXO);
        end
        ng = 0;
        set_rsp(1, 14'h0aa);
        #3;
        if (req_grant[1] === 1'b1) ng++;
        advance();
        C0RxRdValid = 1'b0;
        #3;
        checks++;
        if (rsp_valid !== 4'b0010) begin
            errors++; $display("FAIL max_out_rsp: got %b expected 0010", rsp_valid);
        end
        for (int k = 0; k < 6; k++) begin
            if (k > 0) #3;
            if (req_grant[1] === 1'b1) ng++;
            advance();
        end
        checks++;
        if (ng != 1) begin
            errors++; $display("FAIL max_out_refill: got %0d expected 1", ng);
        end
    endtask

    task automatic test_response_route();
        RxHdr_t                     h;
        logic [CCIP_DATA_WIDTH-1:0] d;
        apply_reset();
        req_valid = 4'b0100;
        advance();
        req_valid = '0;
        set_rsp(2, 14'h0005);
        h = C0RxHdr;
        d = C0RxData;
        h.mdata = 16'h0005;
        advance();
        C0RxRdValid = 1'b0;
        #3;
        checks++;
        if (rsp_valid !== 4'b0100 || rsp_hdr.mdata !== 16'h0005) begin
            errors++; $display("FAIL route_8005: valid %b mdata %h expected 0100 / 0005", rsp_valid, rsp_hdr.mdata);
        end
        checks++;
        if (rsp_hdr !== h || rsp_data !== d || tag_err !== 1'b0) begin
            errors++; $display("FAIL route_payload: hdr %h tag_err %b expected %h / 0", rsp_hdr, tag_err, h);
        end
        advance();
        #3;
        checks++;
        if (rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL route_pulse: got %b expected 0000", rsp_valid);
        end
        advance();
    endtask

    task automatic test_drain();
        apply_reset();
        req_valid = 4'hF;
        advance();
        advance();
        drain_req = 1'b1;
        #3;
        checks++;
        if (req_grant !== 4'b0100) begin
            errors++; $display("FAIL drain_edge_grant: got %b expected 0100", req_grant);
        end
        advance();
        for (int k = 0; k < 4; k++) begin
            #3;
            checks++;
            if (req_grant !== 4'b0000 || drain_done !== 1'b0) begin
                errors++; $display("FAIL drain_hold[%0d]: grant %b done %b expected 0000 / 0", k, req_grant, drain_done);
            end
            advance();
        end
        for (int r = 0; r < 3; r++) begin
            set_rsp(r, 14'(r + 7));
            #3;
            checks++;
            if (drain_done !== 1'b0) begin
                errors++; $display("FAIL drain_early[%0d]: got %b expected 0", r, drain_done);
            end
            advance();
        end
        C0RxRdValid = 1'b0;
        #3;
        checks++;
        if (drain_done !== 1'b1 || rsp_valid !== 4'b0100 || req_grant !== 4'b0000) begin
            errors++; $display("FAIL drain_done: done %b rsp %b grant %b expected 1 / 0100 / 0000", drain_done, rsp_valid, req_grant);
        end
        advance();
        drain_req = 1'b0;
        #3;
        checks++;
        if (drain_done !== 1'b1) begin
            errors++; $display("FAIL drain_release_same: got %b expected 1", drain_done);
        end
        advance();
        #3;
        checks++;
        if (drain_done !== 1'b0 || req_grant !== 4'b1000) begin
            errors++; $display("FAIL drain_release: done %b grant %b expected 0 / 1000", drain_done, req_grant);
        end
        advance();
    endtask

    task automatic test_reset_midop();
        apply_reset();
        req_valid = 4'b1001;
        advance();
        advance();
        req_valid = '0;
        SoftReset = 1'b1;
        advance();
        SoftReset = 1'b0;
        #3;
        checks++;
        if (tag_err !== 1'b0) begin
            errors++; $display("FAIL midop_pre: tag_err %b expected 0", tag_err);
        end
        set_rsp(0, 14'h11);
        advance();
        set_rsp(3, 14'h22);
        #3;
        checks++;
        if (rsp_valid !== 4'b0000 || tag_err !== 1'b1) begin
            errors++; $display("FAIL midop_rsp0: rsp %b tag_err %b expected 0000 / 1", rsp_valid, tag_err);
        end
        advance();
        C0RxRdValid = 1'b0;
        #3;
        checks++;
        if (rsp_valid !== 4'b0000 || tag_err !== 1'b1) begin
            errors++; $display("FAIL midop_rsp3: rsp %b tag_err %b expected 0000 / 1", rsp_valid, tag_err);
        end
        advance();
    endtask

    task automatic test_random();
        int              t;
        int              g;
        logic [NREQ-1:0] exp_g;
        apply_reset();
        for (int c = 0; c < 500; c++) begin
            rand_hdrs();
            req_valid   = 4'($urandom);
            C0TxAlmFull = ($urandom_range(0, 9) < 2);
            if ($urandom_range(0, 39) == 0) drain_req = !drain_req;
            C0RxRdValid = 1'b0;
            t = int'($urandom_range(0, NREQ - 1));
            if (m_cnt[t] > 0 && $urandom_range(0, 9) < 5) set_rsp(t, 14'($urandom));
            else if ($urandom_range(0, 149) == 0) set_rsp(t, 14'($urandom));
            #3;
            g = model_pick();
            exp_g = (g >= 0) ? 4'(1 << g) : 4'b0000;
            checks++;
            if (req_grant !== exp_g) begin
                errors++; $display("FAIL rand_grant[%0d]: got %b expected %b", c, req_grant, exp_g);
            end
            checks++;
            if (C0TxRdValid !== e_txv || (e_txv && C0TxHdr !== e_txhdr)) begin
                errors++; $display("FAIL rand_tx[%0d]: valid %b hdr %h expected %b / %h", c, C0TxRdValid, C0TxHdr, e_txv, e_txhdr);
            end
            checks++;
            if (rsp_valid !== e_rspv || (e_rspv != '0 && (rsp_hdr !== e_rsphdr || rsp_data !== e_rspd))) begin
                errors++; $display("FAIL rand_rsp[%0d]: valid %b hdr %h expected %b / %h", c, rsp_valid, rsp_hdr, e_rspv, e_rsphdr);
            end
            checks++;
            if (tag_err !== m_err || drain_done !== (m_mode == 2)) begin
                errors++; $display("FAIL rand_flags[%0d]: tag_err %b done %b expected %b / %b", c, tag_err, drain_done, m_err, (m_mode == 2));
            end
            advance();
        end
        idle_inputs();
        advance();
    endtask

    initial begin
        idle_inputs();
        SoftReset = 1'b1;
        for (int i = 0; i < NREQ; i++) req_hdr[i] = '0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_almfull();
        test_max_outstanding();
        test_response_route();
        test_drain();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccip_c0tx_arbiter.md
CCIP_C0TX_ARBITER -- requirements
Module: ccip_c0tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of read requesters; legal values are 2 and 4.
REQ-002 Parameter MAX_OUTSTANDING, default 32, SHALL set the per-requester outstanding-read limit; legal range is 1..255.
REQ-003 clk  in  1  SHALL be the single clock; all logic is posedge clk.
REQ-004 SoftReset  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 req_valid  in  NUM_REQ  SHALL be the per-requester read request, held until granted.
REQ-006 req_hdr  in  NUM_REQ x TxHdr_t  SHALL be the per-requester C0 read header; mdata[15:14] must be 0.
REQ-007 req_grant  out  NUM_REQ  SHALL be a one-hot, one-cycle acceptance pulse.
REQ-008 C0TxHdr  out  TxHdr_t  SHALL be the muxed, tagged read header.
REQ-009 C0TxRdValid  out  1  SHALL be the read request valid to CCI-P.
REQ-010 C0TxAlmFull  in  1  SHALL be the CCI-P C0 Tx almost-full backpressure input.
REQ-011 C0RxHdr, C0RxData, C0RxRdValid  in  RxHdr_t, CCIP_DATA_WIDTH, 1  SHALL be the CCI-P read response inputs.
REQ-012 rsp_valid  out  NUM_REQ  SHALL be the one-hot routed response valid.
REQ-013 rsp_hdr, rsp_data  out  RxHdr_t, CCIP_DATA_WIDTH  SHALL be the routed response, with mdata[15:14] cleared.
REQ-014 drain_req  in  1  SHALL be a level request to stop issuing new reads.
REQ-015 drain_done  out  1  SHALL indicate that the arbiter is drained and idle.
REQ-016 tag_err  out  1  SHALL be a sticky flag for a response arriving with no matching outstanding read.

Function
REQ-017 A requester SHALL be eligible when req_valid=1, its outstanding count < MAX_OUTSTANDING, C0TxAlmFull=0, and the FSM is in RUN.
REQ-018 Arbitration SHALL be round-robin: search starts at (last_granted+1) mod NUM_REQ; the pointer starts at 0 after reset.
REQ-019 At most one req_grant SHALL assert per cycle, combinationally in the same cycle as the eligibility it is based on.
REQ-020 C0TxRdValid and C0TxHdr SHALL be registered, asserting exactly one cycle after the grant; C0TxHdr.mdata[15:14] = granted index, all other fields pass through unchanged.
REQ-021 When there is no grant, the next-cycle C0TxRdValid SHALL be 0; C0TxHdr holds its last value.
REQ-022 The outstanding counter (8 bit) of requester i SHALL increment on grant i and decrement on a C0RxRdValid whose mdata[15:14]=i; when both occur in the same cycle it is unchanged.
REQ-023 A response whose tag is >= NUM_REQ, or whose counter is 0, SHALL set tag_err, leave the counter at 0, and produce no rsp_valid.
REQ-024 Responses SHALL be registered with 1-cycle latency: rsp_valid[tag]=1, rsp_hdr = C0RxHdr with mdata[15:14]=0, rsp_data = C0RxData.
REQ-025 The FSM SHALL have three states, RUN, DRAIN and DRAINED:
- RUN -> DRAIN when drain_req=1.
- DRAIN -> DRAINED when all counters are 0 and no grant is in flight.
- DRAINED -> RUN when drain_req=0.
REQ-026 In DRAIN and DRAINED no grants SHALL issue; responses SHALL still route; drain_done=1 only in DRAINED.
REQ-027 A grant issued in the same cycle that drain_req rises SHALL be honored; the FSM enters DRAIN the following cycle.

Reset
REQ-028 During SoftReset=1 the following SHALL hold, overriding any in-flight grant or response:
- C0TxRdValid=0, C0TxHdr=0.
- rsp_valid=0, rsp_hdr=0, rsp_data=0.
- req_grant=0.
- drain_done=0, tag_err=0.
- All counters=0, RR pointer=0, FSM=RUN.
REQ-029 Reset mid-operation SHALL discard the outstanding counts; responses to pre-reset reads arriving afterwards SHALL set tag_err.

Structure
REQ-030 TxHdr_t, RxHdr_t and the constants CCIP_ARB_TAG_MSB=15 and CCIP_ARB_TAG_LSB=14 SHALL reside in ase_pkg.
REQ-031 The round-robin selection SHALL be a sub-module, ccip_rr_picker: combinational, taking (eligible, pointer) and producing a one-hot grant.

Verification
REQ-032 Scenario: all 4 requesters request continuously with AlmFull=0 -> grants cycle 0,1,2,3,0, and C0TxRdValid follows each grant by 1 cycle with mdata[15:14]=0,1,2,3.
REQ-033 Scenario: AlmFull=1 for 5 cycles with requests pending -> no grants; the first grant after AlmFull falls goes to the next RR index.
REQ-034 Scenario: MAX_OUTSTANDING=2 with requester 1 issuing and no responses -> exactly 2 grants; one response tagged 1 permits exactly 1 more grant.
REQ-035 Scenario: a response with mdata=0x8005 -> rsp_valid[2]=1 one cycle later with rsp_hdr.mdata=0x0005.
REQ-036 Scenario: drain_req with 3 reads outstanding -> no grants, drain_done=0; drain_done=1 one cycle after the 3rd response; drain_done=0 once drain_req falls.
REQ-037 Scenario: SoftReset with 2 reads outstanding, then their responses arrive -> tag_err=1 and no rsp_valid.
